// File: rtl/registro_tiempo_cronometro.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : registro_tiempo_cronometro
// Description : Chronometer time-register bank. Holds NUM_FIELDS packed BCD
//               fields (0 = seconds, 1 = minutes, 2 = hours, ...). Fields can
//               be loaded from the bus path (EN) or the user path (ACT), edited
//               with inc/dec (per-field wrap, no carry), and counted down at
//               1 Hz with borrow propagation and a completion pulse.
// Ports       : clk, reset (sync, active-high)
//               seleccion/EN/ACT/EN_deco/addr/din : field load interface
//               inc/dec       : user edit of field addr (IDLE/DONE only)
//               start/stop    : countdown control; tick : 1 Hz enable
//               dato          : packed fields, field i at [8i+7:8i]
//               running/done/load_err : status (done, load_err are pulses)
//               prewarn       : only when CRONO_PREWARN_EN is defined
// Options     : CRONO_PREWARN_EN adds the prewarn output
// Revision    : 1.0 - initial release
// ============================================================================
module registro_tiempo_cronometro #(
  parameter int         NUM_FIELDS = 3,
  parameter int         ADDR_W     = 2,
  parameter logic [7:0] LOW_MAX    = 8'h59,
  parameter logic [7:0] TOP_MAX    = 8'h23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    seleccion,
  input  logic                    EN,
  input  logic                    ACT,
  input  logic                    EN_deco,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [7:0]              din,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    tick,
  output logic [8*NUM_FIELDS-1:0] dato,
  output logic                    running,
  output logic                    done,
  output logic                    load_err
`ifdef CRONO_PREWARN_EN
  ,
  output logic                    prewarn
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [8*NUM_FIELDS-1:0] fields_q, fields_d;
  logic                    running_q, running_d;
  logic                    done_q, done_d;
  logic                    load_err_q, load_err_d;

  logic [31:0]             addr_ext;
  logic                    addr_ok;
  logic [7:0]              sel_limit;
  logic                    din_ok;
  logic                    load_req;
  logic                    any_nz;
  logic [8*NUM_FIELDS-1:0] count_dn;
  logic                    dn_borrow;

  function automatic logic [7:0] field_limit(input int idx);
    return (idx == NUM_FIELDS - 1) ? TOP_MAX : LOW_MAX;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
  endfunction

  assign addr_ext  = 32'(addr);
  assign addr_ok   = (addr_ext < NUM_FIELDS);
  assign sel_limit = (addr_ext == 32'(NUM_FIELDS - 1)) ? TOP_MAX : LOW_MAX;
  assign din_ok    = (din[7:4] <= 4'd9) && (din[3:0] <= 4'd9) && (din <= sel_limit);
  assign load_req  = EN_deco && ((EN && !seleccion) || (ACT && seleccion));
  assign any_nz    = |fields_q;

  // One-second countdown: a field at 00 reloads to its limit and keeps the
  // borrow moving up; the first nonzero field absorbs it.
  always_comb begin
    count_dn  = fields_q;
    dn_borrow = 1'b1;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (dn_borrow) begin
        if (fields_q[8*i +: 8] == 8'h00) begin
          count_dn[8*i +: 8] = field_limit(i);
        end else begin
          count_dn[8*i +: 8] = bcd_dec(fields_q[8*i +: 8]);
          dn_borrow          = 1'b0;
        end
      end
    end
  end

  // Strict per-cycle priority: the highest asserted request owns the cycle
  // and every lower request in that cycle is discarded.
  always_comb begin
    fields_d   = fields_q;
    state_d    = state_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (load_req) begin
      if (addr_ok) begin
        if (din_ok) begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            if (addr_ext == 32'(i)) fields_d[8*i +: 8] = din;
          end
          if (state_q == DONE) state_d = IDLE;
        end else begin
          load_err_d = 1'b1;
        end
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      if (state_q != RUN && any_nz) state_d = RUN;
    end else if (inc || dec) begin
      if (state_q != RUN && addr_ok && (inc != dec)) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (addr_ext == 32'(i)) begin
            if (inc)
              fields_d[8*i +: 8] = (fields_q[8*i +: 8] == field_limit(i)) ?
                                   8'h00 : bcd_inc(fields_q[8*i +: 8]);
            else
              fields_d[8*i +: 8] = (fields_q[8*i +: 8] == 8'h00) ?
                                   field_limit(i) : bcd_dec(fields_q[8*i +: 8]);
          end
        end
      end
    end else if (tick && state_q == RUN) begin
      if (!any_nz) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        fields_d = count_dn;
        if (~|count_dn) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  assign running_d = (state_d == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fields_q   <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fields_q   <= fields_d;
      running_q  <= running_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign dato     = fields_q;
  assign running  = running_q;
  assign done     = done_q;
  assign load_err = load_err_q;

`ifdef CRONO_PREWARN_EN
  logic prewarn_q, prewarn_d;

  // Last ten seconds of a run: every field above seconds is 00.
  assign prewarn_d = (state_d == RUN) &&
                     (fields_d[8*NUM_FIELDS-1:8] == '0) &&
                     (fields_d[7:0] <= 8'h10);

  always_ff @(posedge clk) begin
    if (reset) prewarn_q <= 1'b0;
    else       prewarn_q <= prewarn_d;
  end

  assign prewarn = prewarn_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_registro_tiempo_cronometro.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_registro_tiempo_cronometro
// Description : Directed bench for registro_tiempo_cronometro. A reference
//               model holds the time as decimal integers and counts down via
//               a total-seconds value; it is compared with the DUT after every
//               clock edge, alongside literal expectations at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_registro_tiempo_cronometro;

  localparam int NF = 3;
  localparam int AW = 2;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          seleccion = 1'b0, EN = 1'b0, ACT = 1'b0, EN_deco = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    din = '0;
  logic          inc = 1'b0, dec = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [8*NF-1:0] dato;
  logic          running, done, load_err;
`ifdef CRONO_PREWARN_EN
  logic          prewarn;
`endif

  always #5 clk = ~clk;

  registro_tiempo_cronometro #(
    .NUM_FIELDS(NF), .ADDR_W(AW), .LOW_MAX(8'h59), .TOP_MAX(8'h23)
  ) dut (
    .clk(clk), .reset(reset), .seleccion(seleccion), .EN(EN), .ACT(ACT),
    .EN_deco(EN_deco), .addr(addr), .din(din), .inc(inc), .dec(dec),
    .start(start), .stop(stop), .tick(tick), .dato(dato),
    .running(running), .done(done), .load_err(load_err)
`ifdef CRONO_PREWARN_EN
    , .prewarn(prewarn)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal fields) ----------------
  int mf[NF];
  int mst = M_IDLE;
  bit mdone = 1'b0, merr = 1'b0, menabled = 1'b0;

  function automatic int lim(input int i);
    return (i == NF - 1) ? 23 : 59;
  endfunction

  function automatic int total();
    int t = 0;
    int w = 1;
    for (int i = 0; i < NF; i++) begin
      t += mf[i] * w;
      w *= lim(i) + 1;
    end
    return t;
  endfunction

  task automatic split(input int t);
    int r = t;
    for (int i = 0; i < NF; i++) begin
      mf[i] = r % (lim(i) + 1);
      r     = r / (lim(i) + 1);
    end
  endtask

  function automatic logic [8*NF-1:0] exp_dato();
    logic [8*NF-1:0] e;
    for (int i = 0; i < NF; i++) e[8*i +: 8] = {4'(mf[i] / 10), 4'(mf[i] % 10)};
    return e;
  endfunction

  task automatic model_step();
    int a;
    int t;
    int hi;
    int lo;
    mdone = 1'b0;
    merr  = 1'b0;
    a  = int'(addr);
    hi = int'(din[7:4]);
    lo = int'(din[3:0]);
    if (reset) begin
      for (int i = 0; i < NF; i++) mf[i] = 0;
      mst      = M_IDLE;
      menabled = 1'b1;
    end else if (EN_deco && ((EN && !seleccion) || (ACT && seleccion))) begin
      if (a < NF) begin
        if (hi <= 9 && lo <= 9 && (hi * 10 + lo) <= lim(a)) begin
          mf[a] = hi * 10 + lo;
          if (mst == M_DONE) mst = M_IDLE;
        end else begin
          merr = 1'b1;
        end
      end
    end else if (stop) begin
      mst = M_IDLE;
    end else if (start) begin
      if (mst != M_RUN && total() != 0) mst = M_RUN;
    end else if (inc || dec) begin
      if (mst != M_RUN && a < NF && inc != dec) begin
        if (inc) mf[a] = (mf[a] == lim(a)) ? 0 : mf[a] + 1;
        else     mf[a] = (mf[a] == 0) ? lim(a) : mf[a] - 1;
      end
    end else if (tick && mst == M_RUN) begin
      t = total();
      if (t != 0) begin
        t = t - 1;
        split(t);
      end
      if (t == 0) begin
        mst   = M_DONE;
        mdone = 1'b1;
      end
    end
  endtask

  // Compare process: model advances on each edge, DUT checked 1 ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    if (menabled) begin
      check("cmp_dato", 32'(dato), 32'(exp_dato()));
      check("cmp_running", 32'(running), 32'(mst == M_RUN));
      check("cmp_done", 32'(done), 32'(mdone));
      check("cmp_load_err", 32'(load_err), 32'(merr));
`ifdef CRONO_PREWARN_EN
      check("cmp_prewarn", 32'(prewarn),
            32'(mst == M_RUN && mf[1] == 0 && mf[2] == 0 && mf[0] <= 10));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input bit sel, input int a, input logic [7:0] d);
    seleccion = sel;
    EN = !sel;
    ACT = sel;
    EN_deco = 1'b1;
    addr = AW'(a);
    din = d;
    cyc();
    EN = 1'b0;
    ACT = 1'b0;
    EN_deco = 1'b0;
  endtask

  task automatic ev(input bit i_inc, input bit i_dec, input bit i_start,
                    input bit i_stop, input bit i_tick, input int a);
    inc = i_inc;
    dec = i_dec;
    start = i_start;
    stop = i_stop;
    tick = i_tick;
    addr = AW'(a);
    cyc();
    inc = 1'b0;
    dec = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    tick = 1'b0;
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    check("reset_dato", 32'(dato), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // Bus load, then the same write with the decoder disabled.
    load(1'b0, 1, 8'h45);
    check("bus_load", 32'(dato), 32'h004500);
    seleccion = 1'b0; EN = 1'b1; EN_deco = 1'b0; addr = 2'd1; din = 8'h12;
    cyc();
    EN = 1'b0;
    check("deco_gate", 32'(dato), 32'h004500);
    ev(0, 0, 0, 0, 1, 0);  // tick in IDLE does nothing

    // Rejected loads.
    load(1'b1, 0, 8'h6A);
    check("bad_nibble_err", 32'(load_err), 32'h1);
    check("bad_nibble_dato", 32'(dato), 32'h004500);
    cyc();
    check("err_one_cycle", 32'(load_err), 32'h0);
    load(1'b1, 2, 8'h24);
    check("over_top_err", 32'(load_err), 32'h1);
    load(1'b1, 1, 8'h60);
    check("over_low_err", 32'(load_err), 32'h1);
    load(1'b1, 3, 8'h77);
    check("oor_no_err", 32'(load_err), 32'h0);
    check("oor_dato", 32'(dato), 32'h004500);

    // Edit wrap.
    load(1'b1, 0, 8'h59);
    ev(1, 0, 0, 0, 0, 0);
    check("inc_wrap", 32'(dato), 32'h004500);
    ev(0, 1, 0, 0, 0, 2);
    check("dec_wrap", 32'(dato), 32'h234500);
    ev(1, 1, 0, 0, 0, 1);
    check("inc_dec_both", 32'(dato), 32'h234500);
    ev(1, 0, 0, 0, 0, 1);
    check("inc_plain", 32'(dato), 32'h234600);

    // Borrow chain.
    load(1'b1, 2, 8'h01);
    load(1'b0, 1, 8'h00);
    load(1'b0, 0, 8'h00);
    ev(0, 0, 1, 0, 0, 0);
    ev(0, 0, 0, 0, 1, 0);
    check("borrow_chain", 32'(dato), 32'h005959);
    check("borrow_running", 32'(running), 32'h1);
    ev(1, 0, 0, 0, 0, 0);
    check("inc_in_run", 32'(dato), 32'h005959);
    ev(0, 0, 0, 1, 0, 0);
    check("stop_idle", 32'(running), 32'h0);

    // Completion.
    load(1'b0, 1, 8'h00);
    load(1'b0, 0, 8'h02);
    ev(0, 0, 1, 0, 0, 0);
    ev(0, 0, 0, 0, 1, 0);
    check("cnt_one", 32'(dato), 32'h000001);
    ev(0, 0, 0, 0, 1, 0);
    check("done_pulse", 32'(done), 32'h1);
    check("done_dato", 32'(dato), 32'h0);
    ev(0, 0, 1, 0, 0, 0);
    check("start_zero_done", 32'(done), 32'h0);
    check("start_zero_run", 32'(running), 32'h0);

    // Reset mid-run.
    load(1'b0, 1, 8'h30);
    load(1'b0, 0, 8'h15);
    ev(0, 0, 1, 0, 0, 0);
    check("run_before_reset", 32'(running), 32'h1);
    reset = 1'b1; tick = 1'b1; start = 1'b1;
    cyc();
    reset = 1'b0; tick = 1'b0; start = 1'b0;
    check("midrun_reset_dato", 32'(dato), 32'h0);
    check("midrun_reset_run", 32'(running), 32'h0);
    check("midrun_reset_done", 32'(done), 32'h0);

    // Prewarn window, load during RUN, countdown to completion.
    load(1'b0, 0, 8'h11);
    ev(0, 0, 1, 0, 0, 0);
    ev(0, 0, 0, 0, 1, 0);
    check("pw_dato", 32'(dato), 32'h000010);
`ifdef CRONO_PREWARN_EN
    check("pw_high", 32'(prewarn), 32'h1);
`endif
    tick = 1'b1;
    load(1'b1, 0, 8'h03);
    tick = 1'b0;
    check("load_in_run", 32'(dato), 32'h000003);
    check("load_in_run_state", 32'(running), 32'h1);
    ev(0, 0, 0, 0, 1, 0);
    ev(0, 0, 0, 0, 1, 0);
    ev(0, 0, 0, 0, 1, 0);
    check("final_done", 32'(done), 32'h1);
    load(1'b0, 2, 8'h05);
    check("load_in_done", 32'(dato), 32'h050000);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
